// File: rtl/dbus_sram_resp.sv
// rtl/dbus_sram_resp.sv - data-bus SRAM responder with fixed-latency data_ok; optional DBUS_SRAM_ALIGN_CHECK_EN
module dbus_sram_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dreq_valid_i,
    input  logic [63:0] dreq_addr_i,
    input  logic [2:0]  dreq_size_i,
    input  logic [7:0]  dreq_strobe_i,
    input  logic [63:0] dreq_data_i,
    output logic        dresp_addr_ok_o,
    output logic        dresp_data_ok_o,
`ifdef DBUS_SRAM_ALIGN_CHECK_EN
    output logic        align_err_o,
`endif
    output logic [63:0] dresp_data_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dbus_sram_resp: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q;
    logic [2:0]  size_q;
    logic [7:0]  strobe_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q, rdata_d;

    logic [63:0] mem [DEPTH_WORDS];

    // With LATENCY==1 the read happens on the acceptance edge, before the
    // request is latched, so the live request is used while IDLE.
    logic [63:0]      cur_addr;
    logic [2:0]       cur_size;
    logic             cur_write;
    logic [63:0]      off;
    logic             in_win;
    logic [IDX_W-1:0] idx;
    logic             misalign;
    logic             accept;
    logic             load;
    logic             wr_en;

    assign cur_addr  = (state_q == S_IDLE) ? dreq_addr_i : addr_q;
    assign cur_size  = (state_q == S_IDLE) ? dreq_size_i : size_q;
    assign cur_write = (state_q == S_IDLE) ? (dreq_strobe_i != 8'h00) : (strobe_q != 8'h00);
    assign off       = cur_addr - BASE_ADDR;
    assign in_win    = (cur_addr >= BASE_ADDR) && (off[63:3] < 61'(DEPTH_WORDS));
    assign idx       = off[IDX_W+2:3];

`ifdef DBUS_SRAM_ALIGN_CHECK_EN
    logic align_err_q;

    // A request is misaligned when addr has bits set below its access size.
    always_comb begin
        misalign = 1'b0;
        case (cur_size)
            3'd1:    misalign = cur_addr[0];
            3'd2:    misalign = |cur_addr[1:0];
            3'd3:    misalign = |cur_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // Sticky alignment error, set when a misaligned request reaches its data load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            align_err_q <= 1'b0;
        end else if (load && misalign) begin
            align_err_q <= 1'b1;
        end
    end

    assign align_err_o = align_err_q;
`else
    assign misalign = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{off[2:0], cur_size};

    assign accept = (state_q == S_IDLE) && dreq_valid_i;
    assign load   = (state_d == S_RESP) && (state_q != S_RESP);
    assign wr_en  = (state_q == S_RESP) && (strobe_q != 8'h00) && in_win && !misalign;

    // State, latency counter and response data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 64'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Capture the request on acceptance; held until the next acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= 64'h0;
            size_q   <= 3'd0;
            strobe_q <= 8'h00;
            wdata_q  <= 64'h0;
        end else if (accept) begin
            addr_q   <= dreq_addr_i;
            size_q   <= dreq_size_i;
            strobe_q <= dreq_strobe_i;
            wdata_q  <= dreq_data_i;
        end
    end

    // Next state: the last WAIT cycle is the one whose decrement reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dreq_valid_i) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Response data is loaded on the edge entering RESP and held otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (load) begin
            if (cur_write) begin
                rdata_d = 64'h0;
            end else if (misalign) begin
                rdata_d = 64'hDEAD_BEEF_DEAD_BEEF;
            end else if (!in_win) begin
                rdata_d = 64'h0;
            end else begin
                rdata_d = mem[idx];
            end
        end
    end

    // Strobed write commit on the edge leaving RESP; memory is never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Handshake outputs decoded from state; addr_ok is held low during reset.
    always_comb begin
        dresp_addr_ok_o = rst_ni && (state_q == S_IDLE);
        dresp_data_ok_o = (state_q == S_RESP);
    end

    assign dresp_data_o = rdata_q;

endmodule

// File: tb/tb_dbus_sram_resp.sv
// tb/tb_dbus_sram_resp.sv - scoreboard bench for dbus_sram_resp
module tb_dbus_sram_resp;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] rdata;
`ifdef DBUS_SRAM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q [$];
    logic [63:0] model [int];

    always #5 clk = ~clk;

    dbus_sram_resp #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .dreq_valid_i   (dreq_valid),
        .dreq_addr_i    (dreq_addr),
        .dreq_size_i    (dreq_size),
        .dreq_strobe_i  (dreq_strobe),
        .dreq_data_i    (dreq_data),
        .dresp_addr_ok_o(addr_ok),
        .dresp_data_ok_o(data_ok),
`ifdef DBUS_SRAM_ALIGN_CHECK_EN
        .align_err_o    (align_err),
`endif
        .dresp_data_o   (rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit win(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < 64'(DEPTH * 8));
    endfunction

    function automatic bit mis(input logic [63:0] a, input logic [2:0] sz);
`ifdef DBUS_SRAM_ALIGN_CHECK_EN
        logic [63:0] m;
        m = (64'd1 << sz) - 64'd1;
        return (sz <= 3'd3) && ((a & m) != 64'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [63:0] a);
        logic [63:0] o;
        o = a - BASE;
        return int'(o[12:3]);
    endfunction

    // Pushes the expected response, updates the model, then runs one access.
    task automatic access(input string tag, input logic [63:0] a, input logic [7:0] strb,
                          input logic [63:0] d, input logic [2:0] sz);
        int n;
        logic [63:0] e;
        logic [63:0] w;
        if (strb == 8'h00) begin
            if (mis(a, sz))   e = 64'hDEAD_BEEF_DEAD_BEEF;
            else if (win(a))  e = model[widx(a)];
            else              e = 64'h0;
            exp_q.push_back(e);
        end else begin
            exp_q.push_back(64'h0);
            if (win(a) && !mis(a, sz)) begin
                w = model.exists(widx(a)) ? model[widx(a)] : 64'h0;
                for (int i = 0; i < 8; i++)
                    if (strb[i]) w[8*i +: 8] = d[8*i +: 8];
                model[widx(a)] = w;
            end
        end
        @(negedge clk);
        check({tag, "_addr_ok_idle"}, 64'(addr_ok), 64'd1);
        dreq_valid  = 1'b1;
        dreq_addr   = a;
        dreq_strobe = strb;
        dreq_data   = d;
        dreq_size   = sz;
        @(posedge clk);
        #1;
        dreq_valid  = 1'b0;
        dreq_addr   = {$urandom, $urandom};
        dreq_strobe = 8'($urandom);
        dreq_data   = {$urandom, $urandom};
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (data_ok) break;
            check({tag, "_addr_ok_busy"}, 64'(addr_ok), 64'd0);
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        e = exp_q.pop_front();
        check({tag, "_data"}, rdata, e);
        check({tag, "_addr_ok_resp"}, 64'(addr_ok), 64'd0);
        @(negedge clk);
        check({tag, "_data_ok_pulse"}, 64'(data_ok), 64'd0);
        check({tag, "_data_hold"}, rdata, e);
    endtask

    initial begin
        rst_n       = 1'b0;
        dreq_valid  = 1'b0;
        dreq_addr   = 64'h0;
        dreq_size   = 3'd3;
        dreq_strobe = 8'h00;
        dreq_data   = 64'h0;

        repeat (3) @(negedge clk);
        check("rst_addr_ok", 64'(addr_ok), 64'd0);
        check("rst_data_ok", 64'(data_ok), 64'd0);
        check("rst_data", rdata, 64'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_addr_ok", 64'(addr_ok), 64'd1);

        access("wr8",  64'h8000_0008, 8'hFF, 64'hCAFE_F00D_1234_5678, 3'd3);
        access("rd8",  64'h8000_0008, 8'h00, 64'h0, 3'd3);
        access("wr10", 64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 3'd3);
        access("rd10", 64'h8000_0010, 8'h00, 64'h0, 3'd3);
        access("wr10s", 64'h8000_0010, 8'h0C, 64'h0000_0000_AABB_0000, 3'd3);
        access("rd10s", 64'h8000_0010, 8'h00, 64'h0, 3'd3);
        check("merge_model", model[2], 64'h0123_4567_AABB_CDEF);

        access("wr_last",  64'h8000_1FF8, 8'hFF, 64'h5555_AAAA_5555_AAAA, 3'd3);
        access("wr_first", 64'h8000_0000, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 3'd3);
        access("rd_below", 64'h7FFF_FFF8, 8'h00, 64'h0, 3'd3);
        access("wr_below", 64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3);
        access("wr_above", 64'h8000_2000, 8'hFF, 64'hEEEE_EEEE_EEEE_EEEE, 3'd3);
        access("rd_last",  64'h8000_1FF8, 8'h00, 64'h0, 3'd3);
        access("rd_first", 64'h8000_0000, 8'h00, 64'h0, 3'd3);
        access("rd10_again", 64'h8000_0010, 8'h00, 64'h0, 3'd3);

        // Reset in WAIT of a write: the write must not land.
        access("wr20", 64'h8000_0020, 8'hFF, 64'h1111, 3'd3);
        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = 64'h8000_0020; dreq_strobe = 8'hFF; dreq_data = 64'h2222;
        @(posedge clk);
        #1;
        dreq_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_wait_data_ok", 64'(data_ok), 64'd0);
        check("abort_wait_addr_ok", 64'(addr_ok), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_wait_idle", 64'(addr_ok), 64'd1);
        access("rd20_a", 64'h8000_0020, 8'h00, 64'h0, 3'd3);

        // Reset during RESP: data_ok must drop at once and the write is lost.
        @(negedge clk);
        dreq_valid = 1'b1; dreq_addr = 64'h8000_0020; dreq_strobe = 8'hFF; dreq_data = 64'h3333;
        @(posedge clk);
        #1;
        dreq_valid = 1'b0;
        @(posedge clk);
        #1;
        check("resp_data_ok_high", 64'(data_ok), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_resp_data_ok", 64'(data_ok), 64'd0);
        check("abort_resp_data", rdata, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access("rd20_b", 64'h8000_0020, 8'h00, 64'h0, 3'd3);

`ifdef DBUS_SRAM_ALIGN_CHECK_EN
        check("align_err_clear", 64'(align_err), 64'd0);
        access("rd_mis", 64'h8000_0002, 8'h00, 64'h0, 3'd2);
        check("align_err_set", 64'(align_err), 64'd1);
`else
        access("rd_mis", 64'h8000_0012, 8'h00, 64'h0, 3'd2);
        check("rd_mis_word", model[2], 64'h0123_4567_AABB_CDEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
